fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 31 +++
 rtl/fetch_stage_bht.sv | 42 ++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its branch predictor.
//
// Contents:
//   OP_BRANCH / OP_JAL : 7-bit opcodes of RV32 conditional branches and JAL
//   NOP_INSTR          : canonical bubble instruction (addi x0, x0, 0)
//   ctr_t              : 2-bit saturating predictor counter states
//   ctr_next()         : saturating counter update helper
package fetch_stage_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Move one step toward the resolved outcome, sticking at either end.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        case (cur)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            default: return taken ? ST  : WT;
        endcase
    endfunction

endpackage

// File: rtl/fetch_stage_bht.sv
// Branch history table: an array of 2-bit saturating counters.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset (all entries -> WNT)
//   rd_index    : entry looked up for the instruction being fetched
//   wr_index    : entry updated by the branch resolving in EX
//   outcome     : resolved direction used for the update
//   wr_en       : perform the update this cycle
//   pred_taken  : MSB of the looked-up counter
module branch_history_table
    import fetch_stage_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               outcome,
    input  logic               wr_en,
    output logic               pred_taken
);

    localparam int ENTRIES = 2 ** INDEX_W;

    ctr_t counters [ENTRIES];

    // The read comes straight off the registered array, so a same-cycle
    // update to the same entry is only visible from the next cycle on.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= WNT;
            end
        end else if (wr_en) begin
            counters[wr_index] <= ctr_next(counters[wr_index], outcome);
        end
    end

    assign pred_taken = counters[rd_index][1];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a bimodal branch predictor and IF/ID register.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   clk_gate          : 1 = advance, 0 = hold PC and IF/ID (load-use stall)
//   wrong_prediction  : EX found a misprediction; redirect to correct_pc
//   correct_pc        : redirect target
//   ex_branch_valid   : a conditional branch resolved in EX (trains the BHT)
//   ex_branch_pc      : PC of that branch
//   ex_branch_taken   : its actual direction
//   imem_addr         : current PC to the combinational instruction memory
//   imem_data         : instruction at imem_addr, same cycle
//   IF_ID_*           : pipeline register contents (pc, instr, rs1, rs2,
//                       prediction, valid; valid=0 marks a bubble)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_INDEX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_gate,
    input  logic        wrong_prediction,
    input  logic [31:0] correct_pc,
    input  logic        ex_branch_valid,
    input  logic [31:0] ex_branch_pc,
    input  logic        ex_branch_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic [4:0]  IF_ID_rs1,
    output logic [4:0]  IF_ID_rs2,
    output logic        IF_ID_pred_taken,
    output logic        IF_ID_valid
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] target;
    logic [6:0]  opcode;
    logic        bht_taken;
    logic        pred_taken;
    logic        unused_ex_pc_bits;

    // Only the index bits of the resolving branch PC address the table.
    assign unused_ex_pc_bits = ^{ex_branch_pc[31:BHT_INDEX_W+2], ex_branch_pc[1:0]};

    branch_history_table #(
        .INDEX_W (BHT_INDEX_W)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (pc[BHT_INDEX_W+1:2]),
        .wr_index   (ex_branch_pc[BHT_INDEX_W+1:2]),
        .outcome    (ex_branch_taken),
        .wr_en      (ex_branch_valid),
        .pred_taken (bht_taken)
    );

    assign opcode = imem_data[6:0];

    // Sign-extended immediates; bit 0 of both is implicitly zero.
    assign imm_b = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25],
                    imem_data[11:8], 1'b0};
    assign imm_j = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20],
                    imem_data[30:21], 1'b0};

    // Direction and target of the instruction currently on imem_data.
    always_comb begin
        pred_taken = 1'b0;
        target     = pc + imm_b;
        case (opcode)
            OP_BRANCH: pred_taken = bht_taken;
            OP_JAL: begin
                pred_taken = 1'b1;
                target     = pc + imm_j;
            end
            default: pred_taken = 1'b0;
        endcase
    end

    // A redirect wins over a stall so a flush is never lost behind one.
    always_comb begin
        pc_next = pc + 32'd4;
        if (wrong_prediction) begin
            pc_next = correct_pc;
        end else if (!clk_gate) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID: a flush injects a bubble even while stalled; IF_ID_pc is left
    // as is on a flush because a bubble's PC carries no meaning.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_pc         <= 32'h0;
            IF_ID_instr      <= NOP_INSTR;
            IF_ID_valid      <= 1'b0;
            IF_ID_pred_taken <= 1'b0;
        end else if (wrong_prediction) begin
            IF_ID_instr      <= NOP_INSTR;
            IF_ID_valid      <= 1'b0;
            IF_ID_pred_taken <= 1'b0;
        end else if (clk_gate) begin
            IF_ID_pc         <= pc;
            IF_ID_instr      <= imem_data;
            IF_ID_valid      <= 1'b1;
            IF_ID_pred_taken <= pred_taken;
        end
    end

    assign imem_addr = pc;
    assign IF_ID_rs1 = IF_ID_instr[19:15];
    assign IF_ID_rs2 = IF_ID_instr[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a vector table for the straight-line
// pipeline behaviour followed by hand-built sequences for redirects, BHT
// training, same-cycle update/lookup and reset in the middle of a stall.
module tb_fetch_stage;

    localparam logic [31:0] ADDI     = 32'h0010_0093;
    localparam logic [31:0] ADD      = 32'h0020_81B3;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ_P8   = 32'h0000_0463;
    localparam logic [31:0] BEQ_P20  = 32'h0200_0063;
    localparam logic [31:0] JAL_P10  = 32'h0100_006F;
    localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;
    localparam logic [31:0] JAL_P8   = 32'h0080_006F;

    typedef struct {
        logic        rst;
        logic        gate;
        logic        wp;
        logic [31:0] cpc;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] imem;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_pred;
        logic        chk_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_gate;
    logic        wrong_prediction;
    logic [31:0] correct_pc;
    logic        ex_branch_valid;
    logic [31:0] ex_branch_pc;
    logic        ex_branch_taken;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;
    logic        IF_ID_pred_taken;
    logic        IF_ID_valid;

    int checks = 0;
    int fails  = 0;

    vec_t vecs [11];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .clk_gate         (clk_gate),
        .wrong_prediction (wrong_prediction),
        .correct_pc       (correct_pc),
        .ex_branch_valid  (ex_branch_valid),
        .ex_branch_pc     (ex_branch_pc),
        .ex_branch_taken  (ex_branch_taken),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .IF_ID_pc         (IF_ID_pc),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_rs1        (IF_ID_rs1),
        .IF_ID_rs2        (IF_ID_rs2),
        .IF_ID_pred_taken (IF_ID_pred_taken),
        .IF_ID_valid      (IF_ID_valid)
    );

    function automatic vec_t mkv(
        input logic rst, input logic gate, input logic wp, input logic [31:0] cpc,
        input logic exv, input logic [31:0] expc, input logic ext, input logic [31:0] imem,
        input logic [31:0] e_addr, input logic [31:0] e_pc, input logic [31:0] e_instr,
        input logic e_valid, input logic e_pred, input logic chk_pc);
        vec_t v;
        v.rst = rst; v.gate = gate; v.wp = wp; v.cpc = cpc;
        v.exv = exv; v.expc = expc; v.ext = ext; v.imem = imem;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_pred = e_pred; v.chk_pc = chk_pc;
        return v;
    endfunction

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, clock once, sample at the next falling edge.
    task automatic applyStimulus(input vec_t v);
        reset            = v.rst;
        clk_gate         = v.gate;
        wrong_prediction = v.wp;
        correct_pc       = v.cpc;
        ex_branch_valid  = v.exv;
        ex_branch_pc     = v.expc;
        ex_branch_taken  = v.ext;
        imem_data        = v.imem;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        logic [31:0] ei;
        ei = v.e_instr;
        checkOne({name, ".imem_addr"}, imem_addr, v.e_addr);
        checkOne({name, ".instr"}, IF_ID_instr, ei);
        checkOne({name, ".valid"}, {31'b0, IF_ID_valid}, {31'b0, v.e_valid});
        checkOne({name, ".pred"}, {31'b0, IF_ID_pred_taken}, {31'b0, v.e_pred});
        checkOne({name, ".rs1"}, {27'b0, IF_ID_rs1}, {27'b0, ei[19:15]});
        checkOne({name, ".rs2"}, {27'b0, IF_ID_rs2}, {27'b0, ei[24:20]});
        if (v.chk_pc) begin
            checkOne({name, ".pc"}, IF_ID_pc, v.e_pc);
        end
    endtask

    task automatic runStep(input string name, input vec_t v);
        applyStimulus(v);
        checkOutput(name, v);
    endtask

    initial begin
        // Straight-line pipeline behaviour, starting from PC 0 after reset.
        vecs[0]  = mkv(0,1,0,0,     0,0,0, ADDI,    32'h4,   32'h0,   ADDI, 1,0,1);
        vecs[1]  = mkv(0,1,0,0,     0,0,0, ADD,     32'h8,   32'h4,   ADD,  1,0,1);
        vecs[2]  = mkv(0,1,0,0,     0,0,0, NOP,     32'hC,   32'h8,   NOP,  1,0,1);
        vecs[3]  = mkv(0,1,0,0,     0,0,0, ADD,     32'h10,  32'hC,   ADD,  1,0,1);
        vecs[4]  = mkv(0,0,0,0,     0,0,0, ADDI,    32'h10,  32'hC,   ADD,  1,0,1);
        vecs[5]  = mkv(0,0,0,0,     0,0,0, ADDI,    32'h10,  32'hC,   ADD,  1,0,1);
        vecs[6]  = mkv(0,1,0,0,     0,0,0, NOP,     32'h14,  32'h10,  NOP,  1,0,1);
        vecs[7]  = mkv(0,0,1,32'h200,0,0,0, ADDI,   32'h200, 32'h0,   NOP,  0,0,0);
        vecs[8]  = mkv(0,1,0,0,     0,0,0, BEQ_P8,  32'h204, 32'h200, BEQ_P8, 1,0,1);
        vecs[9]  = mkv(0,1,0,0,     0,0,0, JAL_P10, 32'h214, 32'h204, JAL_P10, 1,1,1);
        vecs[10] = mkv(0,1,1,32'h300,0,0,0, ADDI,   32'h300, 32'h0,   NOP,  0,0,0);

        reset = 1'b1; clk_gate = 1'b1; wrong_prediction = 1'b0; correct_pc = 32'h0;
        ex_branch_valid = 1'b0; ex_branch_pc = 32'h0; ex_branch_taken = 1'b0;
        imem_data = ADDI;
        @(negedge clk);

        runStep("reset", mkv(1,1,0,0, 0,0,0, ADDI, 32'h0, 32'h0, NOP, 0,0,1));

        for (int i = 0; i < 11; i++) begin
            runStep($sformatf("vec%0d", i), vecs[i]);
        end

        // JAL backwards and JAL wrapping past the top of the address space.
        runStep("redir8",    mkv(0,1,1,32'h8,        0,0,0, NOP,    32'h8,        0, NOP, 0,0,0));
        runStep("jal_m8",    mkv(0,1,0,0,            0,0,0, JAL_M8, 32'h0,        32'h8, JAL_M8, 1,1,1));
        runStep("redir_top", mkv(0,1,1,32'hFFFF_FFFC,0,0,0, NOP,    32'hFFFF_FFFC,0, NOP, 0,0,0));
        runStep("jal_wrap",  mkv(0,1,0,0,            0,0,0, JAL_P8, 32'h4,  32'hFFFF_FFFC, JAL_P8, 1,1,1));

        // Train entry of 0x40 to strongly taken, then fetch a BEQ there.
        runStep("train1", mkv(0,1,0,0, 1,32'h40,1, NOP, 32'h8,  32'h4, NOP, 1,0,1));
        runStep("train2", mkv(0,1,0,0, 1,32'h40,1, NOP, 32'hC,  32'h8, NOP, 1,0,1));
        runStep("train3", mkv(0,1,0,0, 1,32'h40,1, NOP, 32'h10, 32'hC, NOP, 1,0,1));
        runStep("redir40a", mkv(0,1,1,32'h40, 0,0,0, NOP, 32'h40, 0, NOP, 0,0,0));
        runStep("beq_taken", mkv(0,1,0,0, 0,0,0, BEQ_P20, 32'h60, 32'h40, BEQ_P20, 1,1,1));
        // An extra taken then one not-taken: a saturating counter stays taken.
        runStep("sat_up",   mkv(0,1,0,0, 1,32'h40,1, NOP, 32'h64, 32'h60, NOP, 1,0,1));
        runStep("step_dn",  mkv(0,1,0,0, 1,32'h40,0, NOP, 32'h68, 32'h64, NOP, 1,0,1));
        runStep("redir40b", mkv(0,1,1,32'h40, 0,0,0, NOP, 32'h40, 0, NOP, 0,0,0));
        runStep("beq_sat",  mkv(0,1,0,0, 0,0,0, BEQ_P20, 32'h60, 32'h40, BEQ_P20, 1,1,1));

        // Reset during a stall, a flush and a BHT update must clear everything.
        runStep("rst_mid",  mkv(1,0,1,32'h500, 1,32'h40,1, NOP, 32'h0, 32'h0, NOP, 0,0,1));
        runStep("bht_init", mkv(0,1,0,0, 0,0,0, BEQ_P20, 32'h4, 32'h0, BEQ_P20, 1,0,1));

        // Same-cycle update and lookup of one entry sees the old counter.
        runStep("redir84a", mkv(0,1,1,32'h84, 0,0,0, NOP, 32'h84, 0, NOP, 0,0,0));
        runStep("same_cyc", mkv(0,1,0,0, 1,32'h84,1, BEQ_P20, 32'h88, 32'h84, BEQ_P20, 1,0,1));
        runStep("redir84b", mkv(0,1,1,32'h84, 0,0,0, NOP, 32'h84, 0, NOP, 0,0,0));
        runStep("after_up", mkv(0,1,0,0, 0,0,0, BEQ_P20, 32'hA4, 32'h84, BEQ_P20, 1,1,1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
